// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder
//
// Pipelined adder/subtractor. The WIDTH-bit operation is split into
// STAGES = WIDTH/BLOCK slices. Each pipeline stage adds one BLOCK-bit slice
// with a carry-lookahead adder built from 4-bit groups. The block carry-out
// is registered and becomes the carry-in of the next stage on the following
// cycle. Subtraction A-B is computed as A + ~B + 1. B is inverted once at
// stage 0, and the inverted upper bits travel down the pipe with the beat.
//
// The handshake is valid/ready. The whole pipe advances together whenever
// the output slot is empty or is being drained (en). in_ready follows en.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all stage registers
//   in_valid   operand beat offered
//   in_ready   beat is accepted this cycle (equals the pipe advance enable)
//   A, B       WIDTH-bit operands
//   C_in       carry-in for addition; ignored when sub = 1
//   sub        0: A + B + C_in, 1: A - B
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   Result     sum or difference, modulo 2^WIDTH
//   C_out      carry out of bit WIDTH-1 (for subtraction: 1 = no borrow)
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             C_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;
  localparam int GROUPS = BLOCK / 4;

  // One BLOCK-bit carry-lookahead slice.
  // The result is packed as {carry into block MSB, block carry-out, sum}.
  // The carry into the MSB is returned so that the last stage can form the
  // signed overflow flag.
  function automatic logic [BLOCK+1:0] cla_block(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK-1:0]  g;
    logic [BLOCK-1:0]  p;
    logic [BLOCK-1:0]  c;
    logic [GROUPS-1:0] gg;
    logic [GROUPS-1:0] gp;
    logic [GROUPS-1:0] gc;
    logic              gm;
    logic              pm;

    g = a & b;
    p = a ^ b;

    // Group generate/propagate for each 4-bit group.
    for (int j = 0; j < GROUPS; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end

    // Carry into each group, resolved from the group terms.
    gc[0] = cin;
    for (int j = 1; j < GROUPS; j++) begin
      gc[j] = gg[j-1] | (gp[j-1] & gc[j-1]);
    end

    // Bit carries inside each group, expanded directly from that group's carry-in.
    for (int j = 0; j < GROUPS; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    // Block-level generate GM and propagate PM.
    // The block carry-out is GM | PM & cin.
    gm = 1'b0;
    pm = 1'b1;
    for (int j = 0; j < GROUPS; j++) begin
      gm = gg[j] | (gp[j] & gm);
      pm = pm & gp[j];
    end

    return {c[BLOCK-1], gm | (pm & cin), p ^ c};
  endfunction

  // Pipe advance enable. Every stage moves together or every stage holds.
  logic en;

  // Stage registers, indexed by stage.
  // res_q holds the result slices finished so far.
  // a_q/b_q hold the operand bits still to be consumed, shifted down so that
  // the next stage always works on bits [BLOCK-1:0]. b_q is already inverted
  // for subtraction.
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];
  logic             ovf_q;

  // Stage inputs and results.
  logic [WIDTH-1:0] in_a    [STAGES];
  logic [WIDTH-1:0] in_b    [STAGES];
  logic [WIDTH-1:0] in_res  [STAGES];
  logic             in_cin  [STAGES];
  logic             in_vld  [STAGES];
  logic [BLOCK+1:0] blk     [STAGES];
  logic [WIDTH-1:0] nxt_res [STAGES];

  assign out_valid = valid_q[STAGES-1];
  assign Result    = res_q[STAGES-1];
  assign C_out     = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // Stage 0 takes its inputs from the ports. The subtract mode is resolved
  // here, by inverting B and forcing the carry-in to 1. Because of this, the
  // mode travels with the beat as already-conditioned operands, and later
  // stages do not need to know about it.
  // Every later stage takes its inputs from the registers of the stage before it.
  always_comb begin
    in_a[0]   = A;
    in_b[0]   = sub ? ~B : B;
    in_cin[0] = sub | C_in;
    in_res[0] = '0;
    in_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_a[k]   = a_q[k-1];
      in_b[k]   = b_q[k-1];
      in_cin[k] = carry_q[k-1];
      in_res[k] = res_q[k-1];
      in_vld[k] = valid_q[k-1];
    end
  end

  // Each stage adds the low slice of its pending operands.
  // It drops the resulting sum into slice k of the accumulated result word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      blk[k]     = cla_block(in_a[k][BLOCK-1:0], in_b[k][BLOCK-1:0], in_cin[k]);
      nxt_res[k] = in_res[k];
      nxt_res[k][k*BLOCK +: BLOCK] = blk[k][BLOCK-1:0];
    end
  end

  // Pipe registers.
  // Data registers load on every advance, even for bubbles. Output data is
  // only meaningful while out_valid is high, so bubble contents do not matter.
  // When en is low, everything holds, and the presented result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        res_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= in_vld[k];
        carry_q[k] <= blk[k][BLOCK];
        res_q[k]   <= nxt_res[k];
        a_q[k]     <= in_a[k] >> BLOCK;
        b_q[k]     <= in_b[k] >> BLOCK;
      end
      // Overflow: the carry into the top bit differs from the carry out of it.
      ovf_q <= blk[STAGES-1][BLOCK+1] ^ blk[STAGES-1][BLOCK];
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_adder
//
// Directed and table-driven bench for pipe_cla_adder.
// Two instances are used:
//   - WIDTH=32, BLOCK=16, latency 2
//   - WIDTH=64, BLOCK=16, latency 4
// Each beat's expected result is queued when the beat is accepted.
// A per-instance monitor compares every cycle in which a result is presented
// against the head of its queue, and pops the entry when the result is taken.
// ---------------------------------------------------------------------------
module tb_pipe_cla_adder;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid32;
  logic        in_valid64;
  logic        out_ready;
  logic        C_in;
  logic        sub;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [63:0] a64;
  logic [63:0] b64;
  logic        in_ready32;
  logic        in_ready64;
  logic        out_valid32;
  logic        out_valid64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic        cout32;
  logic        cout64;
  logic        ovf32;
  logic        ovf64;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sent32 = 0;
  int   sent64 = 0;
  int   recv32 = 0;
  int   recv64 = 0;
  bit   stall_on = 0;
  int   stall_lo = 3;
  int   stream_start = 0;
  exp_t q32[$];
  exp_t q64[$];
  vec_t tbl32 [12];
  vec_t tbl64 [4];

  pipe_cla_adder #(.WIDTH(32), .BLOCK(16)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .A         (a32),
    .B         (b32),
    .C_in      (C_in),
    .sub       (sub),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .Result    (res32),
    .C_out     (cout32),
    .ovf       (ovf32)
  );

  pipe_cla_adder #(.WIDTH(64), .BLOCK(16)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .A         (a64),
    .B         (b64),
    .C_in      (C_in),
    .sub       (sub),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .Result    (res64),
    .C_out     (cout64),
    .ovf       (ovf64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle. Inputs change 1 time unit after the rising edge.
  // out_ready is dropped for stream-relative cycles 3..5 when a stall is armed.
  task automatic stepCycle();
    int rel;
    @(posedge clk);
    #1;
    rel = cyc - stream_start;
    out_ready = !(stall_on && rel >= 3 && rel <= 5);
  endtask

  // Offer one beat. Hold it until the selected instance accepts it, then queue its expected result.
  task automatic applyStimulus(input vec_t v, input bit use64, input bit chk_lat);
    int   waited;
    int   rel;
    bit   done;
    logic rdy;
    exp_t e;
    a32  = v.a[31:0];
    b32  = v.b[31:0];
    a64  = v.a;
    b64  = v.b;
    C_in = v.cin;
    sub  = v.sub;
    in_valid32 = !use64;
    in_valid64 = use64;
    done   = 0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      rdy = use64 ? in_ready64 : in_ready32;
      rel = cyc - stream_start;
      if (stall_on && rel >= stall_lo && rel <= 5)
        checkOutput(use64 ? "in_ready_stall64" : "in_ready_stall32", {63'd0, rdy}, 64'd0);
      if (rdy === 1'b1) begin
        e.res  = v.res;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        e.acc  = cyc;
        e.lat  = chk_lat;
        if (use64) begin
          q64.push_back(e);
          sent64++;
        end else begin
          q32.push_back(e);
          sent32++;
        end
        done = 1;
      end else if (waited >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", waited);
        done = 1;
      end
      waited++;
      stepCycle();
    end
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 60) begin
      stepCycle();
      n++;
    end
    if (q32.size() != 0 || q64.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d/%0d beats outstanding, expected 0", q32.size(), q64.size());
      q32.delete();
      q64.delete();
    end
    repeat (3) stepCycle();
  endtask

  // Random addition beat with the expected result from a plain wide-add reference.
  function automatic vec_t randVec(input bit use64);
    vec_t        v;
    logic [64:0] full;
    v.a   = {$urandom, $urandom};
    v.b   = {$urandom, $urandom};
    v.cin = 1'($urandom_range(0, 1));
    v.sub = 1'b0;
    if (!use64) begin
      v.a[63:32] = '0;
      v.b[63:32] = '0;
      full   = {1'b0, v.a} + {1'b0, v.b} + {64'd0, v.cin};
      v.res  = {32'd0, full[31:0]};
      v.cout = full[32];
      v.ovf  = (v.a[31] == v.b[31]) && (full[31] != v.a[31]);
    end else begin
      full   = {1'b0, v.a} + {1'b0, v.b} + {64'd0, v.cin};
      v.res  = full[63:0];
      v.cout = full[64];
      v.ovf  = (v.a[63] == v.b[63]) && (full[63] != v.a[63]);
    end
    return v;
  endfunction

  task automatic runStream(input bit use64);
    stream_start = cyc;
    stall_lo     = use64 ? 4 : 3;
    stall_on     = 1;
    for (int i = 0; i < 10; i++) applyStimulus(randVec(use64), use64, 0);
    stall_on  = 0;
    out_ready = 1'b1;
    waitDrain();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid32 === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out32: out_valid=1 with result %h, expected no beat", res32);
      end else begin
        checkOutput("result32", {32'd0, res32}, q32[0].res);
        checkOutput("c_out32", {63'd0, cout32}, {63'd0, q32[0].cout});
        checkOutput("ovf32", {63'd0, ovf32}, {63'd0, q32[0].ovf});
        if (out_ready) begin
          if (q32[0].lat) checkOutput("latency32", 64'(cyc - q32[0].acc), 64'd2);
          void'(q32.pop_front());
          recv32++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid64 === 1'b1) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out64: out_valid=1 with result %h, expected no beat", res64);
      end else begin
        checkOutput("result64", res64, q64[0].res);
        checkOutput("c_out64", {63'd0, cout64}, {63'd0, q64[0].cout});
        checkOutput("ovf64", {63'd0, ovf64}, {63'd0, q64[0].ovf});
        if (out_ready) begin
          if (q64[0].lat) checkOutput("latency64", 64'(cyc - q64[0].acc), 64'd4);
          void'(q64.pop_front());
          recv64++;
        end
      end
    end
  end

  initial begin
    //                a                     b                     cin   sub   res                   cout  ovf
    tbl32[0]  = '{64'h0000_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h0001_0000, 1'b0, 1'b0};
    tbl32[1]  = '{64'hFFFF_FFFF, 64'h0000_0000, 1'b1, 1'b0, 64'h0000_0000, 1'b1, 1'b0};
    tbl32[2]  = '{64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1};
    tbl32[3]  = '{64'h0000_0005, 64'h0000_0007, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0};
    tbl32[4]  = '{64'h8000_0000, 64'h0000_0001, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1};
    tbl32[5]  = '{64'h0000_0000, 64'h0000_0000, 1'b1, 1'b1, 64'h0000_0000, 1'b1, 1'b0};
    tbl32[6]  = '{64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b0, 64'hACF1_3569, 1'b0, 1'b0};
    tbl32[7]  = '{64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'h0000_0000, 1'b1, 1'b1};
    tbl32[8]  = '{64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 1'b1};
    tbl32[9]  = '{64'h0001_0000, 64'h0000_0001, 1'b0, 1'b1, 64'h0000_FFFF, 1'b1, 1'b0};
    tbl32[10] = '{64'h0000_FFFF, 64'h0000_0000, 1'b1, 1'b0, 64'h0001_0000, 1'b0, 1'b0};
    tbl32[11] = '{64'hFFFF_0000, 64'h0001_0000, 1'b0, 1'b0, 64'h0000_0000, 1'b1, 1'b0};

    tbl64[0]  = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    tbl64[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    tbl64[2]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl64[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    rst_n      = 1'b0;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    out_ready  = 1'b1;
    C_in       = 1'b0;
    sub        = 1'b0;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;

    #2;
    checkOutput("reset_out_valid32", {63'd0, out_valid32}, 64'd0);
    checkOutput("reset_result32", {32'd0, res32}, 64'd0);
    checkOutput("reset_c_out32", {63'd0, cout32}, 64'd0);
    checkOutput("reset_ovf32", {63'd0, ovf32}, 64'd0);
    checkOutput("reset_in_ready32", {63'd0, in_ready32}, 64'd1);
    checkOutput("reset_out_valid64", {63'd0, out_valid64}, 64'd0);
    checkOutput("reset_result64", res64, 64'd0);
    checkOutput("reset_in_ready64", {63'd0, in_ready64}, 64'd1);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    // Single beats with idle gaps: checks function and 2-cycle latency.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl32[i], 0, 1);
      repeat (3) stepCycle();
    end

    // Same table back to back: add and subtract beats interleave with no flush.
    for (int i = 0; i < 12; i++) applyStimulus(tbl32[i], 0, 1);
    waitDrain();

    runStream(0);

    // Reset while two beats are in flight.
    applyStimulus(tbl32[0], 0, 1);
    applyStimulus(tbl32[2], 0, 1);
    rst_n = 1'b0;
    sent32 -= q32.size();
    q32.delete();
    #1;
    checkOutput("midreset_out_valid32", {63'd0, out_valid32}, 64'd0);
    checkOutput("midreset_result32", {32'd0, res32}, 64'd0);
    checkOutput("midreset_in_ready32", {63'd0, in_ready32}, 64'd1);
    a32 = 32'hDEAD_BEEF;
    b32 = 32'h0BAD_F00D;
    in_valid32 = 1'b1;
    stepCycle();
    in_valid32 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset_out_valid32", {63'd0, out_valid32}, 64'd0);
    stepCycle();
    applyStimulus(tbl32[3], 0, 1);
    waitDrain();

    // 64-bit instance: four stages.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl64[i], 1, 1);
      repeat (4) stepCycle();
    end
    for (int i = 0; i < 4; i++) applyStimulus(tbl64[i], 1, 1);
    waitDrain();
    runStream(1);

    checkOutput("beats32", 64'(recv32), 64'(sent32));
    checkOutput("beats64", 64'(recv64), 64'(sent64));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of BLOCK, at least BLOCK.
REQ-002 SHALL have parameter BLOCK, default 16, width of each carry-lookahead block; legal values are 4, 8, 16 or 32.
REQ-003 SHALL define localparam STAGES = WIDTH/BLOCK as the pipeline depth.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 C_in  input  1  carry-in; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+C_in; 1 = A-B, computed as A+~B+1.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 Result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-015 C_out  output  1  carry out of bit WIDTH-1; for sub=1 this means no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Stage k (k = 0..STAGES-1) SHALL compute block k (bits k*BLOCK+BLOCK-1 : k*BLOCK) with a 4-bit-group carry-lookahead.
- Uses per-block generate GM and propagate PM.
- Carry-in comes from stage k-1's registered carry; stage 0 uses C_in or 1.
REQ-018 Each stage SHALL register:
- its result slice;
- the block carry-out, GM | PM & cin;
- a valid bit;
- the not-yet-consumed upper operand bits, with B already inverted for sub.
REQ-019 A beat is accepted when in_valid && in_ready; its result SHALL appear on out_valid exactly STAGES cycles later when there is no stall.
REQ-020 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-021 Stall: en = !out_valid || out_ready; in_ready SHALL equal en.
- When en = 0, all stage registers SHALL hold.
- Inputs are not sampled while in_ready = 0.
REQ-022 While out_valid = 1 and out_ready = 0, Result, C_out and ovf SHALL remain stable.
REQ-023 Bubbles (in_valid = 0 while en = 1) SHALL propagate as invalid stages.
- Output data is don't-care while out_valid = 0.
REQ-024 ovf SHALL equal carry into bit WIDTH-1 XOR C_out.
REQ-025 A beat's sub and C_in SHALL travel with that beat; mode changes between consecutive beats take effect per beat with no flush.
REQ-026 With STAGES = 1, latency SHALL be 1 cycle and the same handshake rules apply.

Reset
REQ-027 rst_n = 0 SHALL asynchronously clear every stage valid bit, so out_valid = 0.
- Result = 0, C_out = 0, ovf = 0; stage data registers also cleared to 0.
REQ-028 During reset, in_ready SHALL be 1, because out_valid = 0 forces en = 1; beats presented while rst_n = 0 SHALL be discarded.
REQ-029 Reset asserted mid-operation SHALL drop all in-flight beats; no partial result is ever emitted.
REQ-030 The first beat accepted on the first rising edge after rst_n deasserts SHALL behave normally.

Verification (WIDTH=32, BLOCK=16, latency 2)
REQ-031 A=0x0000FFFF, B=0x00000001, C_in=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, Result=0x00010000, C_out=0, ovf=0. Checks the inter-stage carry.
REQ-032 A=0xFFFFFFFF, B=0, C_in=1 -> Result=0, C_out=1, ovf=0; then A=0x7FFFFFFF, B=1, C_in=0 -> Result=0x80000000, ovf=1.
REQ-033 sub=1, A=5, B=7 -> Result=0xFFFFFFFE, C_out=0; then sub=1, A=0x80000000, B=1 -> Result=0x7FFFFFFF, ovf=1. Issue back-to-back with alternating sub=0 beats and check per-beat mode.
REQ-034 Stream 10 random beats with out_ready low for cycles 3-5.
- in_ready drops while the output holds; outputs stay stable.
- No beat is lost or duplicated; results are in order and match the reference A+B+C_in.
REQ-035 Accept 2 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately and stays 0; the next beat after release emits exactly 2 cycles after acceptance.
REQ-036 Repeat REQ-031 and REQ-034 with WIDTH=64, BLOCK=16 -> latency 4; A=0x0000FFFFFFFFFFFF, B=1 -> Result=0x0001000000000000.
